rca_serial_adder: RTL
=====================

// Module: rca_serial_adder
// PURPOSE
//   Parametrised multi-cycle ripple-carry adder. Computes s = a + b + ci over WIDTH bits, CHUNK bits per clock.
//   A small CHUNK-bit ripple slice is reused each cycle, and the carry is held in a register between cycles.
//   Start/busy/done handshake; serves as the area-lean successor to the fixed 4-bit RCA datapath.
// PARAMETERS
//   WIDTH  16  operand/sum width in bits; must be a multiple of CHUNK
//   CHUNK   4  bits added per cycle; 1 <= CHUNK <= WIDTH
//   NCHK   WIDTH/CHUNK  (localparam) cycles per addition
// PORTS
//   clk    in   1      rising-edge clock; single clock domain
//   reset  in   1      synchronous, active-high reset
//   start  in   1      request; sampled at posedge only while busy==0
//   a      in   WIDTH  operand A; captured on accepted start
//   b      in   WIDTH  operand B; captured on accepted start
//   ci     in   1      carry-in; captured on accepted start
//   busy   out  1      high while an addition is in progress
//   done   out  1      one-cycle pulse; s/co/ovf are valid from this cycle on
//   s      out  WIDTH  sum result
//   co     out  1      carry-out of bit WIDTH-1
//   ovf    out  1      two's-complement overflow, equal to (a[MSB]==b[MSB]) && (s[MSB]!=a[MSB])
// BEHAVIOUR
//   Reset (reset==1 at posedge): FSM=IDLE; busy=0, done=0, s=0, co=0, ovf=0; internal regs and carry cleared.
//   Reset dominates every other input. Reset mid-operation aborts the add, and no done pulse is produced.
//   FSM has two states, IDLE and BUSY.
//   IDLE, start==1: latch a, b and ci into shift regs and the carry reg; chunk counter k=0; go to BUSY.
//   IDLE, start==0: hold all outputs.
//   BUSY, each posedge:
//     - add chunk k of A, chunk k of B and the carry reg with a CHUNK-bit ripple.
//     - write the CHUNK sum bits into the internal accumulator at bits [k*CHUNK +: CHUNK].
//     - update the carry reg and increment k.
//   BUSY, at the posedge where k==NCHK-1:
//     - load s, co and ovf from the completed accumulator and carry.
//     - done<=1 for exactly one cycle; busy<=0; return to IDLE.
//   Latency: start accepted at edge E0 -> done high after edge E0+NCHK; busy high after E0 through E0+NCHK-1.
//   start while busy==1 is ignored; no queuing, and the in-flight operands are unaffected.
//   Back-to-back: start may be asserted in the done cycle, since the FSM is then IDLE; the next done follows NCHK cycles later.
//   s/co/ovf change only on completion and hold the last result across later idle and busy cycles.
//   Operand inputs may change freely after the accept edge.
//   Arithmetic is modulo 2^WIDTH; carry beyond bit WIDTH-1 appears only on co.
//   CHUNK==WIDTH degenerates to a 1-cycle add; the handshake is unchanged.
// TESTING (WIDTH=16, CHUNK=4 unless noted)
//   1 Reset held 3 cycles -> busy=0, done=0, s=16'h0000, co=0, ovf=0.
//   2 a=16'h00FF, b=16'h0001, ci=0, start 1 cycle -> done exactly 4 cycles later; s=16'h0100, co=0, ovf=0.
//   3 a=16'hFFFF, b=16'h0000, ci=1 -> s=16'h0000, co=1, ovf=0; then a=16'h7FFF, b=16'h0001, ci=0 -> s=16'h8000, co=0, ovf=1.
//   4 start re-pulsed at cycle 2 of a busy add with new operands -> ignored; the first result holds.
//     Start held high through the done cycle -> second add accepted with no gap.
//   5 reset asserted on the 2nd busy cycle -> next cycle busy=0; no done pulse; s=0, co=0.
//   6 WIDTH=4, CHUNK=1 and WIDTH=4, CHUNK=4: exhaustive a, b, ci (512 cases) -> {co,s}==a+b+ci each time, done after 4 and 1 cycles.

Source files
------------

// File: rtl/rca_serial_adder.sv
// Multi-cycle ripple-carry adder: one CHUNK-bit ripple slice is reused each cycle.
// The inter-chunk carry is held in a register. Start/busy/done handshake.

module rca_fa (
    input  logic x,
    input  logic y,
    input  logic cin,
    output logic sum,
    output logic cout
);
    assign sum  = x ^ y ^ cin;
    assign cout = (x & y) | (cin & (x ^ y));
endmodule

module rca_serial_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             co,
    output logic             ovf
);
    localparam int NCHK = WIDTH / CHUNK;
    localparam int KW   = (NCHK > 1) ? $clog2(NCHK) : 1;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_sh, b_sh, acc, acc_nxt;
    logic             carry;
    logic [KW-1:0]    k;
    logic [CHUNK-1:0] slice_sum;
    logic [CHUNK:0]   cy;
    logic             accept, last, ovf_nxt;

    // Operands shift right each cycle, so the active chunk is always the low CHUNK bits.
    assign cy[0] = carry;
    for (genvar i = 0; i < CHUNK; i++) begin : g_slice
        rca_fa u_fa (
            .x   (a_sh[i]),
            .y   (b_sh[i]),
            .cin (cy[i]),
            .sum (slice_sum[i]),
            .cout(cy[i+1])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        last      = 1'b0;
        case (state)
            IDLE: if (start) begin
                accept    = 1'b1;
                state_nxt = BUSY;
            end
            BUSY: if (k == KW'(NCHK - 1)) begin
                last      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        acc_nxt = acc;
        acc_nxt[int'(k) * CHUNK +: CHUNK] = slice_sum;
    end

    // On the final chunk the low bits of the shifted operands hold the original MSBs.
    assign ovf_nxt = (a_sh[CHUNK-1] == b_sh[CHUNK-1]) && (slice_sum[CHUNK-1] != a_sh[CHUNK-1]);

    always_ff @(posedge clk) begin
        if (reset) begin
            a_sh  <= '0;
            b_sh  <= '0;
            acc   <= '0;
            carry <= 1'b0;
            k     <= '0;
            done  <= 1'b0;
            s     <= '0;
            co    <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            done <= last;
            if (accept) begin
                a_sh  <= a;
                b_sh  <= b;
                carry <= ci;
                k     <= '0;
                acc   <= '0;
            end else if (state == BUSY) begin
                a_sh  <= a_sh >> CHUNK;
                b_sh  <= b_sh >> CHUNK;
                carry <= cy[CHUNK];
                k     <= k + KW'(1);
                acc   <= acc_nxt;
                if (last) begin
                    s   <= acc_nxt;
                    co  <= cy[CHUNK];
                    ovf <= ovf_nxt;
                end
            end
        end
    end

    assign busy = (state == BUSY);
endmodule
